// File: rtl/imem_boot_loader_pkg.sv
// Shared types and default widths for the instruction-memory boot loader.
// IMEM_BOOT_CHECKSUM_EN adds the trailing checksum state.
package imem_boot_loader_pkg;

    localparam int ADDR_W_DEF    = 10;
    localparam int INST_W_DEF    = 32;
    localparam int BYTE_W_DEF    = 8;
    localparam int MAX_WORDS_DEF = 1024;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_WRITE = 3'd2,
        ST_DONE  = 3'd3,
`ifdef IMEM_BOOT_CHECKSUM_EN
        ST_ERR   = 3'd4,
        ST_CHK   = 3'd5
`else
        ST_ERR   = 3'd4
`endif
    } state_e;

    function automatic int bytes_per_word(input int inst_w, input int byte_w);
        return inst_w / byte_w;
    endfunction

endpackage

// File: rtl/imem_boot_loader_if.sv
// Byte-stream input and instruction-memory write bundles for the boot loader.
// The stream master drives bytes; the write master drives memory.
interface imem_boot_stream_if #(
    parameter int BYTE_W = 8
);
    logic              valid;
    logic [BYTE_W-1:0] data;
    logic              last;
    logic              ready;

    modport master (output valid, output data, output last, input ready);
    modport slave  (input valid, input data, input last, output ready);
endinterface

interface imem_boot_wr_if #(
    parameter int ADDR_W = 10,
    parameter int INST_W = 32
);
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [INST_W-1:0] wdata;

    modport master (output we, output addr, output wdata);
    modport slave  (input we, input addr, input wdata);
endinterface

// File: rtl/imem_boot_loader_byte_packer.sv
// MSB-first byte packer: shifts bytes into a word and counts byte slots.
// Clear has priority over load-enable.
module imem_boot_loader_byte_packer
    import imem_boot_loader_pkg::*;
#(
    parameter int INST_W = INST_W_DEF,
    parameter int BYTE_W = BYTE_W_DEF,
    parameter int NB     = bytes_per_word(INST_W, BYTE_W),
    parameter int CNT_W  = $clog2(NB)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              clr_i,
    input  logic              en_i,
    input  logic [BYTE_W-1:0] byte_i,
    output logic [INST_W-1:0] word_o,
    output logic [CNT_W-1:0]  cnt_o
);

    logic [INST_W-1:0] word_q, word_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    always_comb begin
        word_d = word_q;
        cnt_d  = cnt_q;
        if (clr_i) begin
            word_d = '0;
            cnt_d  = '0;
        end else if (en_i) begin
            word_d = {word_q[INST_W-BYTE_W-1:0], byte_i};
            cnt_d  = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            word_q <= '0;
            cnt_q  <= '0;
        end else begin
            word_q <= word_d;
            cnt_q  <= cnt_d;
        end
    end

    assign word_o = word_q;
    assign cnt_o  = cnt_q;

endmodule

// File: rtl/imem_boot_loader.sv
// Streams bytes into instruction memory from address 0, then releases the CPU.
// Optional IMEM_BOOT_CHECKSUM_EN verifies a trailing XOR byte before release.
module imem_boot_loader
    import imem_boot_loader_pkg::*;
#(
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int INST_W    = INST_W_DEF,
    parameter int BYTE_W    = BYTE_W_DEF,
    parameter int MAX_WORDS = MAX_WORDS_DEF
) (
    input  logic              clock_i,
    input  logic              reset_i,
    input  logic              start_i,
    imem_boot_stream_if.slave in_i,
    imem_boot_wr_if.master    imem_o,
    output logic              cpu_run_o,
    output logic [ADDR_W:0]   words_loaded_o,
    output logic              error_o
);

    localparam int NB    = bytes_per_word(INST_W, BYTE_W);
    localparam int CNT_W = $clog2(NB);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NB - 1);
    localparam logic [ADDR_W:0]  MAX_CNT  = (ADDR_W + 1)'(MAX_WORDS);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W:0]   words_q, words_d;
    logic              last_q, last_d;
`ifdef IMEM_BOOT_CHECKSUM_EN
    logic [BYTE_W-1:0] xor_q, xor_d;
`endif

    logic              rdy;
    logic              accept;
    logic              pk_clr;
    logic              pk_en;
    logic [INST_W-1:0] pk_word;
    logic [CNT_W-1:0]  pk_cnt;

    imem_boot_loader_byte_packer #(
        .INST_W (INST_W),
        .BYTE_W (BYTE_W),
        .NB     (NB),
        .CNT_W  (CNT_W)
    ) u_packer (
        .clk_i  (clock_i),
        .rst_i  (reset_i),
        .clr_i  (pk_clr),
        .en_i   (pk_en),
        .byte_i (in_i.data),
        .word_o (pk_word),
        .cnt_o  (pk_cnt)
    );

`ifdef IMEM_BOOT_CHECKSUM_EN
    assign rdy = (state_q == ST_LOAD) || (state_q == ST_CHK);
`else
    assign rdy = (state_q == ST_LOAD);
`endif
    assign accept = in_i.valid && rdy;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        words_d = words_q;
        last_d  = last_q;
        pk_clr  = 1'b0;
        pk_en   = 1'b0;
`ifdef IMEM_BOOT_CHECKSUM_EN
        xor_d   = xor_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d = ST_LOAD;
                    addr_d  = '0;
                    words_d = '0;
                    last_d  = 1'b0;
                    pk_clr  = 1'b1;
`ifdef IMEM_BOOT_CHECKSUM_EN
                    xor_d   = '0;
`endif
                end
            end
            ST_LOAD: begin
                // Overflow is judged before the byte enters the packer.
                if (accept) begin
                    if (words_q == MAX_CNT) begin
                        state_d = ST_ERR;
                    end else begin
                        pk_en = 1'b1;
`ifdef IMEM_BOOT_CHECKSUM_EN
                        xor_d = xor_q ^ in_i.data;
`endif
                        if (pk_cnt == LAST_IDX) begin
                            state_d = ST_WRITE;
                            last_d  = in_i.last;
                        end else if (in_i.last) begin
                            state_d = ST_ERR;
                        end
                    end
                end
            end
            ST_WRITE: begin
                addr_d  = addr_q + ADDR_W'(1);
                words_d = words_q + (ADDR_W + 1)'(1);
`ifdef IMEM_BOOT_CHECKSUM_EN
                state_d = last_q ? ST_CHK : ST_LOAD;
`else
                state_d = last_q ? ST_DONE : ST_LOAD;
`endif
            end
`ifdef IMEM_BOOT_CHECKSUM_EN
            ST_CHK: begin
                if (accept) begin
                    state_d = (in_i.data == xor_q) ? ST_DONE : ST_ERR;
                end
            end
`endif
            ST_DONE: state_d = ST_DONE;
            ST_ERR:  state_d = ST_ERR;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            words_q <= '0;
            last_q  <= 1'b0;
`ifdef IMEM_BOOT_CHECKSUM_EN
            xor_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            words_q <= words_d;
            last_q  <= last_d;
`ifdef IMEM_BOOT_CHECKSUM_EN
            xor_q   <= xor_d;
`endif
        end
    end

    assign in_i.ready     = rdy;
    assign imem_o.we      = (state_q == ST_WRITE);
    assign imem_o.addr    = addr_q;
    assign imem_o.wdata   = pk_word;
    assign cpu_run_o      = (state_q == ST_DONE);
    assign error_o        = (state_q == ST_ERR);
    assign words_loaded_o = words_q;

endmodule
